move_tick_gen: RTL

//  Consumer side of the speed-select interface: takes the 7-bit frequency code
//  (period in 10 ms units, 100 = 1 s, 25 = 250 ms) and produces the snake move

---
 rtl/move_tick_gen.sv | 113 +++++++++++
 1 files changed

// File: rtl/move_tick_gen.sv
// move_tick_gen: turns the 7-bit move period code (10 ms units) into a
// one-cycle snake move strobe plus a pending flag held until the game FSM
// acknowledges the move.
// Optional feature macro: MOVE_TICK_OVERRUN_EN adds the overrun_cnt port,
// which counts boundaries that arrive while a previous move is still unacked.
module move_tick_gen #(
  parameter int PRESCALE = 500000,  // clk cycles per 10 ms unit, >= 2
  parameter int PS_W     = 19       // must hold PRESCALE-1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] frequency,
  input  logic       tick_ack,
  output logic       tick,
  output logic       tick_pending,
  output logic [6:0] period_q,
  output logic [6:0] unit_cnt
`ifdef MOVE_TICK_OVERRUN_EN
  ,
  output logic [7:0] overrun_cnt
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [PS_W-1:0] ps_cnt;
  logic            unit_stb;
  logic            boundary;
  logic [6:0]      freq_eff;

  // A code of 0 would mean an empty interval; treat it as the shortest one.
  assign freq_eff = (frequency == 7'd0) ? 7'd1 : frequency;
  assign unit_stb = (ps_cnt == PS_W'(PRESCALE - 1));
  // period_q is never 0 in RUN, so period_q-1 cannot underflow there.
  assign boundary = (state_q == RUN) && enable && unit_stb &&
                    (unit_cnt == (period_q - 7'd1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: enable alone moves between stopped and running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timing datapath: prescaler, unit counter, strobe and pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_cnt       <= '0;
      unit_cnt     <= '0;
      period_q     <= '0;
      tick         <= 1'b0;
      tick_pending <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state_q)
        IDLE: begin
          ps_cnt       <= '0;
          unit_cnt     <= '0;
          tick_pending <= 1'b0;
          // Entry edge latches the period so the first interval is full length.
          if (enable) period_q <= freq_eff;
        end
        RUN: begin
          if (!enable) begin
            ps_cnt       <= '0;
            unit_cnt     <= '0;
            tick_pending <= 1'b0;
          end else begin
            ps_cnt <= unit_stb ? '0 : ps_cnt + PS_W'(1);
            if (unit_stb) unit_cnt <= boundary ? 7'd0 : unit_cnt + 7'd1;
            if (boundary) begin
              tick         <= 1'b1;
              // New move wins over a same-edge ack.
              tick_pending <= 1'b1;
              // Period changes only land here, never mid-interval.
              period_q     <= freq_eff;
            end else if (tick_ack) begin
              tick_pending <= 1'b0;
            end
          end
        end
        default: begin
          ps_cnt       <= '0;
          unit_cnt     <= '0;
          tick_pending <= 1'b0;
        end
      endcase
    end
  end

`ifdef MOVE_TICK_OVERRUN_EN
  // Saturating count of moves dropped because the previous one was never acked;
  // survives enable=0 so the game can read it after a stop.
  always_ff @(posedge clk) begin
    if (rst)
      overrun_cnt <= '0;
    else if (boundary && tick_pending && !tick_ack && (overrun_cnt != 8'hFF))
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule
